// File: rtl/edge_bram_arbiter.sv
// edge_bram_arbiter: serializes the edge writer, contour tracer and display
// reader onto the single BRAM port. Returns read data to the issuing client
// RD_LAT+1 cycles after its grant.
module edge_bram_arbiter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // edge writer
  input  logic        req_wr,
  input  logic        we_wr,
  input  logic [18:0] addr_wr,
  input  logic [2:0]  wdata_wr,
  output logic        gnt_wr,
  output logic        rvalid_wr,
  output logic [2:0]  rdata_wr,
  // contour tracer
  input  logic        req_tr,
  input  logic        we_tr,
  input  logic [18:0] addr_tr,
  input  logic [2:0]  wdata_tr,
  output logic        gnt_tr,
  output logic        rvalid_tr,
  output logic [2:0]  rdata_tr,
  // display reader
  input  logic        req_dp,
  input  logic        we_dp,
  input  logic [18:0] addr_dp,
  input  logic [2:0]  wdata_dp,
  output logic        gnt_dp,
  output logic        rvalid_dp,
  output logic [2:0]  rdata_dp,
  // BRAM port
  output logic [18:0] bram_addr,
  output logic        bram_we,
  output logic [2:0]  bram_din,
  input  logic [2:0]  bram_dout,
  output logic        oob_err
);

  localparam int AW = 19;
  localparam int DW = 3;
  localparam int NCLI = 3;
  localparam logic [AW-1:0] PIX = AW'(WIDTH * HEIGHT);
  localparam logic [1:0] ID_WR = 2'd0;
  localparam logic [1:0] ID_TR = 2'd1;
  localparam logic [1:0] ID_DP = 2'd2;
  localparam logic RR_WR = 1'b0;
  localparam logic RR_TR = 1'b1;

  // Return-path tag: which client issued the read and whether it was out of range.
  typedef struct packed {
    logic [1:0] id;
    logic       oob;
  } tag_t;

  logic                      rr;       // preferred client among wr/tr
  logic                      any_gnt;
  logic                      sel_we;
  logic                      sel_oob;
  logic [AW-1:0]             sel_addr;
  logic [DW-1:0]             sel_din;
  logic [1:0]                sel_id;
  logic [RD_LAT:0]           vld_pipe; // read issued, per stage
  tag_t [RD_LAT:0]           tag_pipe;
  logic [NCLI-1:0]           rvalid;
  logic [NCLI-1:0][DW-1:0]   rdata;

  // Fixed priority for the display, round-robin between writer and tracer.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_tr = 1'b0;
    gnt_dp = 1'b0;
    if (req_dp) begin
      gnt_dp = 1'b1;
    end else if (req_wr && req_tr) begin
      gnt_wr = (rr == RR_WR);
      gnt_tr = (rr == RR_TR);
    end else begin
      gnt_wr = req_wr;
      gnt_tr = req_tr;
    end
  end

  // Steer the winning client's request onto the BRAM side.
  always_comb begin
    any_gnt  = gnt_wr | gnt_tr | gnt_dp;
    sel_id   = ID_WR;
    sel_we   = we_wr;
    sel_addr = addr_wr;
    sel_din  = wdata_wr;
    if (gnt_dp) begin
      sel_id   = ID_DP;
      sel_we   = we_dp;
      sel_addr = addr_dp;
      sel_din  = wdata_dp;
    end else if (gnt_tr) begin
      sel_id   = ID_TR;
      sel_we   = we_tr;
      sel_addr = addr_tr;
      sel_din  = wdata_tr;
    end
    sel_oob = (sel_addr >= PIX);
  end

  // BRAM port registers, round-robin pointer and sticky out-of-range flag.
  // Out-of-range accesses are accepted but never write the memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bram_addr <= '0;
      bram_we   <= 1'b0;
      bram_din  <= '0;
      rr        <= RR_WR;
      oob_err   <= 1'b0;
    end else begin
      bram_we <= any_gnt & sel_we & ~sel_oob;
      if (any_gnt) begin
        bram_addr <= sel_addr;
        bram_din  <= sel_din;
      end
      if (gnt_wr)      rr <= RR_TR;
      else if (gnt_tr) rr <= RR_WR;
      if (any_gnt && sel_oob) oob_err <= 1'b1;
    end
  end

  // Tag shift register; stage RD_LAT lines up with bram_dout of that read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= any_gnt & ~sel_we;
      tag_pipe[0] <= tag_t'{id: sel_id, oob: sel_oob};
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  generate
    for (genvar k = 0; k < NCLI; k++) begin : g_ret
      assign rvalid[k] = vld_pipe[RD_LAT] && (tag_pipe[RD_LAT].id == 2'(k));
      assign rdata[k]  = (rvalid[k] && !tag_pipe[RD_LAT].oob) ? bram_dout : '0;
    end
  endgenerate

  assign rvalid_wr = rvalid[ID_WR];
  assign rvalid_tr = rvalid[ID_TR];
  assign rvalid_dp = rvalid[ID_DP];
  assign rdata_wr  = rdata[ID_WR];
  assign rdata_tr  = rdata[ID_TR];
  assign rdata_dp  = rdata[ID_DP];

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Bench for edge_bram_arbiter: directed scenarios plus random traffic, with a
// write-first BRAM model, a reference arbiter/memory and per-client return queues.
module tb_edge_bram_arbiter;

  localparam int PIX = 640 * 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_wr, we_wr, gnt_wr, rvalid_wr;
  logic [18:0] addr_wr;
  logic [2:0]  wdata_wr, rdata_wr;
  logic        req_tr, we_tr, gnt_tr, rvalid_tr;
  logic [18:0] addr_tr;
  logic [2:0]  wdata_tr, rdata_tr;
  logic        req_dp, we_dp, gnt_dp, rvalid_dp;
  logic [18:0] addr_dp;
  logic [2:0]  wdata_dp, rdata_dp;
  logic [18:0] bram_addr;
  logic        bram_we;
  logic [2:0]  bram_din, bram_dout;
  logic        oob_err;

  always #5 clk = ~clk;

  edge_bram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_wr(req_wr), .we_wr(we_wr), .addr_wr(addr_wr), .wdata_wr(wdata_wr),
    .gnt_wr(gnt_wr), .rvalid_wr(rvalid_wr), .rdata_wr(rdata_wr),
    .req_tr(req_tr), .we_tr(we_tr), .addr_tr(addr_tr), .wdata_tr(wdata_tr),
    .gnt_tr(gnt_tr), .rvalid_tr(rvalid_tr), .rdata_tr(rdata_tr),
    .req_dp(req_dp), .we_dp(we_dp), .addr_dp(addr_dp), .wdata_dp(wdata_dp),
    .gnt_dp(gnt_dp), .rvalid_dp(rvalid_dp), .rdata_dp(rdata_dp),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .bram_dout(bram_dout), .oob_err(oob_err)
  );

  // Write-first single-port BRAM, two cycles from registered address to dout.
  bit [2:0] bmem [524288];
  bit [2:0] bd1, bd2;
  always @(posedge clk) begin
    if (bram_we === 1'b1) bmem[bram_addr] <= bram_din;
    bd1 <= (bram_we === 1'b1) ? bram_din : bmem[bram_addr];
    bd2 <= bd1;
  end
  assign bram_dout = bd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic        req;
    logic        we;
    logic [18:0] addr;
    logic [2:0]  wd;
  } creq_t;
  typedef struct {
    int       due;
    logic [2:0] d;
  } exp_t;

  creq_t      c [3];            // 0 = wr, 1 = tr, 2 = dp
  bit [2:0]   shadow [524288];  // memory contents as the clients see them
  exp_t       rq [3][$];        // outstanding reads per client
  int         pref = 0;         // preferred of wr(0)/tr(1)
  logic       exp_we = 1'b0;
  logic [18:0] exp_addr = '0;
  logic [2:0] exp_din = '0;
  logic       exp_oob = 1'b0;
  bit         mon_on = 1'b0;

  // Monitor: pop the expected return whenever a client sees rvalid.
  task automatic ret_chk(input int k, input logic v, input logic [2:0] d);
    exp_t e;
    if (v === 1'b1) begin
      if (rq[k].size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected client=%0d cyc=%0d got=1 want=0", k, cyc);
      end else begin
        e = rq[k].pop_front();
        chk($sformatf("rdata_c%0d", k), d, e.d);
        chk($sformatf("rlat_c%0d", k), cyc, e.due);
      end
    end else if (rq[k].size() > 0 && rq[k][0].due <= cyc) begin
      e = rq[k].pop_front();
      total++;
      bad++;
      $display("FAIL rvalid_missing client=%0d cyc=%0d got=0 want=1 due=%0d", k, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      ret_chk(0, rvalid_wr, rdata_wr);
      ret_chk(1, rvalid_tr, rdata_tr);
      ret_chk(2, rvalid_dp, rdata_dp);
      if (!rst_n) chk("rdata_in_reset", {rdata_wr, rdata_tr, rdata_dp}, 0);
    end
  end

  task automatic drive();
    req_wr = c[0].req; we_wr = c[0].we; addr_wr = c[0].addr; wdata_wr = c[0].wd;
    req_tr = c[1].req; we_tr = c[1].we; addr_tr = c[1].addr; wdata_tr = c[1].wd;
    req_dp = c[2].req; we_dp = c[2].we; addr_dp = c[2].addr; wdata_dp = c[2].wd;
  endtask

  // One cycle, starting and ending at a falling edge.
  task automatic step();
    int w;
    logic oob;
    exp_t e;
    chk("bram_we", bram_we, exp_we);
    chk("bram_addr", bram_addr, exp_addr);
    if (exp_we) chk("bram_din", bram_din, exp_din);
    chk("oob_err", oob_err, exp_oob);
    drive();
    #1;
    w = -1;
    if (c[2].req)                  w = 2;
    else if (c[0].req && c[1].req) w = pref;
    else if (c[0].req)             w = 0;
    else if (c[1].req)             w = 1;
    chk("gnt", {gnt_dp, gnt_tr, gnt_wr}, (w < 0) ? 0 : (1 << w));
    exp_we = 1'b0;
    if (w >= 0) begin
      oob = (c[w].addr >= PIX);
      exp_addr = c[w].addr;
      exp_din  = c[w].wd;
      if (c[w].we) begin
        exp_we = !oob;
        if (!oob) shadow[c[w].addr] = c[w].wd;
      end else begin
        e.due = cyc + 3;
        e.d   = oob ? 3'd0 : shadow[c[w].addr];
        rq[w].push_back(e);
      end
      if (oob) exp_oob = 1'b1;
      if (w == 0) pref = 1;
      else if (w == 1) pref = 0;
      c[w].req = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [18:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      16:      return 19'd307199;
      17:      return 19'd307200;
      18:      return 19'd524287;
      19:      return 19'd641;
      default: return 19'(r);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) c[k] = '{1'b0, 1'b0, 19'd0, 3'd0};
    drive();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    step();  // idle after reset: everything zero

    // writer stores 5 at 641, tracer reads it back
    c[0] = '{1'b1, 1'b1, 19'd641, 3'b101};
    step();
    c[1] = '{1'b1, 1'b0, 19'd641, 3'd0};
    step();
    repeat (4) step();

    // wr and tr contend for 8 cycles: strict alternation
    for (int i = 0; i < 8; i++) begin
      c[0] = '{1'b1, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
      c[1] = '{1'b1, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
      step();
    end
    repeat (4) step();

    // display holds priority for 5 cycles, then wr goes first
    c[0] = '{1'b1, 1'b0, 19'd3, 3'd0};
    c[1] = '{1'b1, 1'b0, 19'd4, 3'd0};
    for (int i = 0; i < 5; i++) begin
      c[2] = '{1'b1, 1'b0, 19'(i), 3'd0};
      step();
    end
    step();
    step();
    repeat (4) step();

    // out-of-range tracer write, then in-range read
    c[0] = '{1'b1, 1'b1, 19'd307199, 3'b110};
    step();
    c[1] = '{1'b1, 1'b1, 19'd307200, 3'b111};
    step();
    c[1] = '{1'b1, 1'b0, 19'd307199, 3'd0};
    step();
    repeat (4) step();

    // reset while a tracer read is in flight
    c[1] = '{1'b1, 1'b0, 19'd641, 3'd0};
    step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) rq[k].delete();
    step();
    exp_addr = '0; exp_din = '0; exp_oob = 1'b0; pref = 0;
    repeat (3) step();
    rst_n = 1'b1;
    c[0] = '{1'b1, 1'b0, 19'd1, 3'd0};
    c[1] = '{1'b1, 1'b0, 19'd2, 3'd0};
    step();
    step();
    repeat (4) step();

    // interleaved display and tracer reads
    for (int i = 0; i < 4; i++) begin
      c[2] = '{1'b1, 1'b0, 19'(i), 3'd0};
      step();
      c[1] = '{1'b1, 1'b0, 19'(100 + i), 3'd0};
      step();
    end
    repeat (4) step();

    // random traffic; pending requests are held until granted
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (!c[k].req && ($urandom_range(0, 3) < ((k == 2) ? 1 : 2))) begin
          c[k].req  = 1'b1;
          c[k].we   = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
          c[k].addr = rnd_addr();
          c[k].wd   = 3'($urandom_range(0, 7));
        end
      end
      step();
    end
    for (int k = 0; k < 3; k++) c[k].req = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 3; k++) chk($sformatf("drain_c%0d", k), rq[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
